// File: rtl/parity_frame_ctrl_pkg.sv
// Shared types and constants for the parity frame controller.
// Pure declarations; no latency or flow control of its own.
package parity_frame_ctrl_pkg;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        SHIFT = 2'd1,
        HOLD  = 2'd2
    } state_t;

    localparam int SYM_W_DEF = 8;

    // Largest value a cnt_w-bit counter can hold; used as the saturation ceiling.
    function automatic logic [31:0] sat_max(input int cnt_w);
        return (32'd1 << cnt_w) - 32'd1;
    endfunction

endpackage

// File: rtl/sym_parity.sv
// Even-parity check of one symbol: err = 1 when the symbol has an odd number of ones.
// Purely combinational, zero latency, no flow control.
module sym_parity
    import parity_frame_ctrl_pkg::*;
#(
    parameter int SYM_W = SYM_W_DEF
) (
    input  logic [SYM_W-1:0] sym,
    output logic             err
);

    assign err = ^sym;

endmodule

// File: rtl/parity_frame_ctrl.sv
// Deserialises bits into parity-checked symbols, counts errors per frame; symValid one cycle after last bit.
// Holds the symbol until symValid && symReady; bits arriving while holding are dropped and flag overrun.
module parity_frame_ctrl
    import parity_frame_ctrl_pkg::*;
#(
    parameter int SYM_W     = SYM_W_DEF,
    parameter int FRAME_LEN = 16,
    parameter int CNT_W     = 8
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
    input  logic             bitIn,
    input  logic             bitValid,
    output logic [SYM_W-1:0] symOut,
    output logic             symErr,
    output logic             symValid,
    input  logic             symReady,
    output logic [CNT_W-1:0] errCount,
    output logic             frameDone,
    output logic             busy,
    output logic             overrun
);

    localparam int               BC_W     = $clog2(SYM_W);
    localparam logic [BC_W-1:0]  LAST_BIT = BC_W'(SYM_W - 1);
    localparam logic [7:0]       LAST_SYM = 8'(FRAME_LEN - 1);
    localparam logic [CNT_W-1:0] CNT_MAX  = CNT_W'(sat_max(CNT_W));

    state_t           state;
    state_t           state_nxt;
    logic [SYM_W-1:0] shreg;
    logic [SYM_W-1:0] shreg_nxt;
    logic [BC_W-1:0]  bit_cnt;
    logic [7:0]       sym_idx;
    logic             par_err;
    logic             bit_take;
    logic             sym_done;
    logic             handshake;
    logic             last_sym;

    assign shreg_nxt = {shreg[SYM_W-2:0], bitIn};
    assign bit_take  = (state == SHIFT) && bitValid;
    assign sym_done  = bit_take && (bit_cnt == LAST_BIT);
    assign handshake = (state == HOLD) && symValid && symReady;
    assign last_sym  = (sym_idx == LAST_SYM);

    // Parity is taken on the value about to be latched so symErr lands with symOut.
    sym_parity #(.SYM_W(SYM_W)) u_parity (
        .sym (shreg_nxt),
        .err (par_err)
    );

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state <= IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    always_comb begin
        state_nxt = state;
        case (state)
            IDLE:    if (start)     state_nxt = SHIFT;
            SHIFT:   if (sym_done)  state_nxt = HOLD;
            HOLD:    if (handshake) state_nxt = last_sym ? IDLE : SHIFT;
            default:                state_nxt = IDLE;
        endcase
    end

    always_comb begin
        busy = (state != IDLE);
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            shreg     <= '0;
            bit_cnt   <= '0;
            sym_idx   <= '0;
            symOut    <= '0;
            symErr    <= 1'b0;
            symValid  <= 1'b0;
            errCount  <= '0;
            frameDone <= 1'b0;
            overrun   <= 1'b0;
        end else begin
            frameDone <= 1'b0;
            case (state)
                IDLE: begin
                    if (start) begin
                        errCount <= '0;
                        overrun  <= 1'b0;
                        bit_cnt  <= '0;
                        sym_idx  <= '0;
                    end
                end
                SHIFT: begin
                    if (bit_take) begin
                        shreg <= shreg_nxt;
                        if (sym_done) begin
                            symOut   <= shreg_nxt;
                            symErr   <= par_err;
                            symValid <= 1'b1;
                            bit_cnt  <= '0;
                        end else begin
                            bit_cnt <= bit_cnt + BC_W'(1);
                        end
                    end
                end
                HOLD: begin
                    if (bitValid) begin
                        overrun <= 1'b1;
                    end
                    if (handshake) begin
                        symValid <= 1'b0;
                        if (symErr && (errCount != CNT_MAX)) begin
                            errCount <= errCount + CNT_W'(1);
                        end
                        if (last_sym) begin
                            sym_idx   <= '0;
                            frameDone <= 1'b1;
                        end else begin
                            sym_idx <= sym_idx + 8'd1;
                        end
                    end
                end
                default: ;
            endcase
        end
    end

endmodule

// File: tb/tb_parity_frame_ctrl.sv
// Directed + randomized bench for parity_frame_ctrl (FRAME_LEN=4, CNT_W=2 so saturation is reachable).
module tb_parity_frame_ctrl;

    localparam int FL = 4;
    localparam int CW = 2;
    localparam int SW = 8;

    logic          clk = 1'b0;
    logic          rst;
    logic          start;
    logic          bitIn;
    logic          bitValid;
    logic          symReady;
    logic [SW-1:0] symOut;
    logic          symErr;
    logic          symValid;
    logic [CW-1:0] errCount;
    logic          frameDone;
    logic          busy;
    logic          overrun;

    int   n_cmp  = 0;
    int   n_fail = 0;
    int   exp_total;
    int   exp_idx;
    logic exp_ovr;

    always #5 clk = ~clk;

    parity_frame_ctrl #(.SYM_W(SW), .FRAME_LEN(FL), .CNT_W(CW)) dut (
        .clk       (clk),
        .rst       (rst),
        .start     (start),
        .bitIn     (bitIn),
        .bitValid  (bitValid),
        .symOut    (symOut),
        .symErr    (symErr),
        .symValid  (symValid),
        .symReady  (symReady),
        .errCount  (errCount),
        .frameDone (frameDone),
        .busy      (busy),
        .overrun   (overrun)
    );

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
        end
    endtask

    function automatic logic par(input logic [7:0] s);
        return ($countones(s) % 2) == 1;
    endfunction

    function automatic int exp_cnt();
        int cmax;
        cmax = (1 << CW) - 1;
        return (exp_total > cmax) ? cmax : exp_total;
    endfunction

    task automatic do_start(input logic junk_bv);
        start    = 1'b1;
        bitValid = junk_bv;
        bitIn    = 1'($urandom);
        @(negedge clk);
        start     = 1'b0;
        bitValid  = 1'b0;
        exp_total = 0;
        exp_idx   = 0;
        exp_ovr   = 1'b0;
        check("start_busy", busy, 1);
        check("start_errcnt", errCount, 0);
        check("start_ovr", overrun, 0);
    endtask

    // Drives the first nbits of s MSB-first with random idle gaps; start may be pulsed on bit start_at.
    task automatic send_bits(input logic [7:0] s, input int nbits, input int gap_max,
                             input int start_at, input logic rdy);
        for (int i = 0; i < nbits; i++) begin
            int g;
            g = $urandom_range(0, gap_max);
            for (int k = 0; k < g; k++) begin
                bitValid = 1'b0;
                symReady = rdy;
                @(negedge clk);
            end
            bitValid = 1'b1;
            bitIn    = s[7-i];
            start    = (i == start_at);
            symReady = rdy;
            if (i == 7) check("pre_valid", symValid, 0);
            @(negedge clk);
            start    = 1'b0;
            bitValid = 1'b0;
        end
    endtask

    task automatic send_sym(input logic [7:0] s, input int gap_max, input int start_at,
                            input logic rdy, input int hold, input int pulses);
        logic last;
        send_bits(s, 8, gap_max, start_at, rdy);
        check("sym_valid", symValid, 1);
        check("sym_out", symOut, s);
        check("sym_err", symErr, par(s));
        exp_total += int'(par(s));
        for (int k = 0; k < hold; k++) begin
            symReady = 1'b0;
            bitValid = (k < pulses);
            bitIn    = 1'($urandom);
            @(negedge clk);
            bitValid = 1'b0;
            check("hold_out", symOut, s);
            check("hold_valid", symValid, 1);
        end
        if (pulses > 0 && hold > 0) exp_ovr = 1'b1;
        symReady = 1'b1;
        bitValid = 1'b0;
        @(negedge clk);
        symReady = rdy;
        last = (exp_idx == FL - 1);
        check("acc_valid", symValid, 0);
        check("acc_errcnt", errCount, exp_cnt());
        check("acc_ovr", overrun, exp_ovr);
        check("acc_done", frameDone, last);
        check("acc_busy", busy, !last);
        exp_idx = last ? 0 : exp_idx + 1;
        if (last) begin
            @(negedge clk);
            check("done_pulse", frameDone, 0);
            check("idle_busy", busy, 0);
        end
    endtask

    initial begin
        logic [7:0] r;
        rst      = 1'b1;
        start    = 1'b0;
        bitIn    = 1'b0;
        bitValid = 1'b0;
        symReady = 1'b0;
        exp_total = 0;
        exp_idx   = 0;
        exp_ovr   = 1'b0;
        repeat (3) @(negedge clk);
        check("rst_symout", symOut, 0);
        check("rst_symerr", symErr, 0);
        check("rst_symvalid", symValid, 0);
        check("rst_errcnt", errCount, 0);
        check("rst_done", frameDone, 0);
        check("rst_busy", busy, 0);
        check("rst_ovr", overrun, 0);
        rst = 1'b0;

        // Bits in IDLE are ignored.
        for (int i = 0; i < 5; i++) begin
            bitValid = 1'b1;
            bitIn    = 1'($urandom);
            @(negedge clk);
        end
        bitValid = 1'b0;
        check("idle_ignore_busy", busy, 0);
        check("idle_ignore_valid", symValid, 0);

        // Frame A: ready tied high, HOLD overrun, mid-frame start pulse.
        do_start(1'b1);
        send_sym(8'h01, 0, -1, 1'b1, 0, 0);
        send_sym(8'hA5, 1, -1, 1'b0, 5, 2);
        r = 8'($urandom);
        send_sym(r, 1, 3, 1'b0, 1, 0);
        r = 8'($urandom);
        send_sym(r, 2, -1, 1'b0, 0, 0);
        for (int i = 0; i < 4; i++) begin
            bitValid = 1'(i % 2);
            bitIn    = 1'b1;
            @(negedge clk);
        end
        bitValid = 1'b0;
        check("idle_hold_errcnt", errCount, exp_cnt());
        check("idle_hold_ovr", overrun, exp_ovr);

        // Frame B: parity sequence 0,1,0,1.
        do_start(1'b0);
        send_sym(8'hFF, 0, -1, 1'b1, 0, 0);
        send_sym(8'hFE, 0, -1, 1'b1, 0, 0);
        send_sym(8'h03, 0, -1, 1'b1, 0, 0);
        send_sym(8'h80, 0, -1, 1'b1, 0, 0);
        symReady = 1'b0;

        // Frame C: counter saturation.
        do_start(1'b0);
        for (int i = 0; i < FL; i++) send_sym(8'h01, 1, -1, 1'b0, 1, 0);

        // Random frames.
        for (int f = 0; f < 3; f++) begin
            do_start(1'($urandom));
            for (int i = 0; i < FL; i++) begin
                r = 8'($urandom);
                send_sym(r, 2, -1, 1'($urandom), $urandom_range(0, 3), $urandom_range(0, 1));
            end
            symReady = 1'b0;
        end

        // Frame D: reset after 3 symbols and 5 bits of the 4th.
        do_start(1'b0);
        send_sym(8'h01, 1, -1, 1'b0, 2, 1);
        for (int i = 0; i < 2; i++) begin
            r = 8'($urandom);
            send_sym(r, 1, -1, 1'b0, 1, 0);
        end
        r = 8'($urandom);
        send_bits(r, 5, 1, -1, 1'b0);
        rst = 1'b1;
        #1;
        check("arst_symout", symOut, 0);
        check("arst_symvalid", symValid, 0);
        check("arst_errcnt", errCount, 0);
        check("arst_busy", busy, 0);
        check("arst_ovr", overrun, 0);
        check("arst_done", frameDone, 0);
        for (int i = 0; i < 3; i++) begin
            bitValid = 1'b1;
            bitIn    = 1'($urandom);
            @(negedge clk);
            check("arst_no_done", frameDone, 0);
        end
        bitValid = 1'b0;
        rst = 1'b0;
        @(negedge clk);
        check("post_rst_busy", busy, 0);

        // Frame E after reset: index and count start from zero.
        do_start(1'b0);
        for (int i = 0; i < FL; i++) begin
            r = 8'($urandom);
            send_sym(r, 1, -1, 1'b0, $urandom_range(0, 2), 0);
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

endmodule
